// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: data width, FSM state
// encoding and the clocks-per-bit arithmetic.
package uart_pkg;

    localparam int DATA_W = 8;
    localparam int ST_W   = 3;

    localparam logic [ST_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [ST_W-1:0] ST_START     = 3'd1;
    localparam logic [ST_W-1:0] ST_DATA      = 3'd2;
    localparam logic [ST_W-1:0] ST_STOP      = 3'd3;
    localparam logic [ST_W-1:0] ST_WAIT_HIGH = 3'd4;

    // Clocks per line bit (truncating division).
    function automatic int bit_clks(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Clocks from the falling edge of the start bit to its middle.
    function automatic int half_clks(input int clk_freq, input int baud);
        return bit_clks(clk_freq, baud) / 2;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO for received bytes. The head entry is kept in a
// register so the consumer sees a flop output; it holds its last value
// when the FIFO drains.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int fifo_depth = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              full_o,
    output logic              empty_o,
    output logic [DATA_W-1:0] head_o
);

    localparam int PW = $clog2(fifo_depth);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(fifo_depth);

    logic [DATA_W-1:0] mem_q [fifo_depth];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic              do_push, do_pop;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign head_o  = head_q;

    // A push into a full FIFO only lands if a pop frees the slot this cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer/count update and next head value after this cycle's ops.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
        head_d   = head_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (do_pop) begin
            if (cnt_q > CW'(1))  head_d = mem_q[rd_ptr_q + PW'(1)];
            else if (do_push)    head_d = wdata_i;
        end else if (empty_o && do_push) begin
            head_d = wdata_i;
        end
    end

    // Control state with async reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            head_q   <= head_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_rx_sampler.sv
// 8N1 UART receiver: two-flop line synchronizer, mid-bit sampling FSM,
// sticky framing/overrun flags and a small output FIFO.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int clk_freq       = 100000000,
    parameter int uart_baud_rate = 1152000,
    parameter int fifo_depth     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rxd,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    input  logic              err_clr,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int D  = bit_clks(clk_freq, uart_baud_rate);
    localparam int H  = half_clks(clk_freq, uart_baud_rate);
    localparam int CW = (D > 1) ? $clog2(D) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(D - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);

    logic              sync1_q, sync2_q, line;
    logic [ST_W-1:0]   state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;
    logic              push, pop, ferr_set, ovr_set;
    logic              fifo_full, fifo_empty;

    assign line      = sync2_q;
    assign rx_valid  = !fifo_empty;
    assign pop       = rx_valid && rx_ready;
    assign ovr_set   = push && fifo_full && !pop;
    assign busy      = (state_q != ST_IDLE);
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

    // Bring the asynchronous line into the clk domain; idles high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= uart_rxd;
            sync2_q <= sync1_q;
        end
    end

    // Frame FSM: start bit checked at half a bit, then one sample per bit.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        push     = 1'b0;
        ferr_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!line) state_d = ST_START;
            end
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (line) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        bit_d   = 3'd0;
                    end
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {line, shift_q[DATA_W-1:1]};
                    if (bit_q == 3'd7) state_d = ST_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (line) begin
                        push    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = ST_WAIT_HIGH;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                // A held-low break parks here so it reports a single error.
                cnt_d = '0;
                if (line) state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sticky flags: a set event in the same cycle as err_clr wins.
    always_comb begin
        frame_err_d = ferr_set || (frame_err_q && !err_clr);
        overrun_d   = ovr_set  || (overrun_q   && !err_clr);
    end

    // FSM and flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    uart_rx_fifo #(
        .fifo_depth(fifo_depth)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (push),
        .pop_i  (pop),
        .wdata_i(shift_q),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .head_o (rx_data)
    );

endmodule
